shift_seq_unit: RTL and testbench

Parametrised sequential shifter, the next generation of our 4-bit fixed left-shift block. It generalises the width, adds four shift modes and a runtime shift amount, and performs one bit position per clock. A start/busy/done handshake lets the datapath controller issue operations and collect registered results. It also reports the carry, which is the last bit shifted or rotated out.

---
 rtl/shift_seq_unit.sv | 112 +++++++++++
 tb/tb_shift_seq_unit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/shift_seq_unit.sv
// Sequential shifter: one bit position per clock in LSL/LSR/ASR/ROL mode,
// with start/busy/done handshake and a registered carry of the last bit out.
module shift_seq_unit #(
  parameter int WIDTH = 4,
  parameter int AW    = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [AW-1:0]    amt,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] y,
  output logic             carry,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [1:0] M_LSL = 2'b00;
  localparam logic [1:0] M_LSR = 2'b01;
  localparam logic [1:0] M_ASR = 2'b10;

  state_t           state_q;
  logic [WIDTH-1:0] sr_q;
  logic [AW-1:0]    cnt_q;
  logic [1:0]       m_q;
  logic             c_q;
  logic [WIDTH-1:0] y_q;
  logic             carry_q;
  logic             busy_q;
  logic             done_q;

  logic [WIDTH:0]   step_d;
  logic [AW-1:0]    cnt_d;

  // Returns {bit shifted out, shifted word} for a single-position step.
  function automatic logic [WIDTH:0] shift_step(input logic [1:0] md,
                                                input logic [WIDTH-1:0] v);
    case (md)
      M_LSL:   return {v[WIDTH-1], v[WIDTH-2:0], 1'b0};
      M_LSR:   return {v[0], 1'b0, v[WIDTH-1:1]};
      M_ASR:   return {v[0], v[WIDTH-1], v[WIDTH-1:1]};
      default: return {v[WIDTH-1], v[WIDTH-2:0], v[WIDTH-1]};
    endcase
  endfunction

  assign step_d = shift_step(m_q, sr_q);
  assign cnt_d  = cnt_q - AW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      m_q     <= '0;
      c_q     <= 1'b0;
      y_q     <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            sr_q  <= a;
            cnt_q <= amt;
            m_q   <= mode;
            c_q   <= 1'b0;
            // A zero amount completes at once with the operand unchanged.
            if (amt == '0) begin
              y_q     <= a;
              carry_q <= 1'b0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              busy_q  <= 1'b1;
              state_q <= SHIFT;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        SHIFT: begin
          sr_q  <= step_d[WIDTH-1:0];
          c_q   <= step_d[WIDTH];
          cnt_q <= cnt_d;
          if (cnt_q == AW'(1)) begin
            y_q     <= step_d[WIDTH-1:0];
            carry_q <= step_d[WIDTH];
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign y     = y_q;
  assign carry = carry_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_shift_seq_unit.sv
// Bench for shift_seq_unit: a WIDTH=4 and a WIDTH=8 instance checked every
// cycle against an arithmetic reference, plus directed literal cases.
module tb_shift_seq_unit;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       st[2];
  logic [7:0] ia[2];
  logic [3:0] iamt[2];
  logic [1:0] imd[2];

  logic [3:0] y4;
  logic [7:0] y8;
  logic [7:0] dy[2];
  logic       dc[2], db[2], dd[2];

  int n_cmp = 0;
  int n_bad = 0;

  shift_seq_unit #(.WIDTH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .a(ia[0][3:0]), .amt(iamt[0][2:0]),
    .mode(imd[0]), .y(y4), .carry(dc[0]), .busy(db[0]), .done(dd[0]));

  shift_seq_unit #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .a(ia[1]), .amt(iamt[1]),
    .mode(imd[1]), .y(y8), .carry(dc[1]), .busy(db[1]), .done(dd[1]));

  assign dy[0] = {4'b0000, y4};
  assign dy[1] = y8;

  // Reference result {carry, y} from closed-form shift arithmetic.
  function automatic logic [8:0] ref_op(int w, logic [1:0] md, logic [7:0] a, int n);
    int mask, av, sgn, yy, cc, r;
    mask = (1 << w) - 1;
    av   = int'(a) & mask;
    sgn  = (av >> (w - 1)) & 1;
    yy = 0; cc = 0;
    case (md)
      2'b00: begin
        yy = (n >= w) ? 0 : ((av << n) & mask);
        cc = (n >= 1 && n <= w) ? ((av >> (w - n)) & 1) : 0;
      end
      2'b01: begin
        yy = (n >= w) ? 0 : (av >> n);
        cc = (n >= 1 && n <= w) ? ((av >> (n - 1)) & 1) : 0;
      end
      2'b10: begin
        if (n >= w) begin
          yy = (sgn != 0) ? mask : 0;
          cc = sgn;
        end else begin
          yy = (av >> n) | ((sgn != 0) ? (mask & ~(mask >> n)) : 0);
          cc = (n >= 1) ? ((av >> (n - 1)) & 1) : 0;
        end
      end
      default: begin
        r  = n % w;
        yy = ((av << r) | (av >> (w - r))) & mask;
        cc = (n >= 1) ? (yy & 1) : 0;
      end
    endcase
    return {cc[0], yy[7:0]};
  endfunction

  int       rem[2];
  bit [7:0] ey[2], py[2];
  bit       ec[2], pc[2], eb[2], ed[2];

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      logic [8:0] r;
      int w;
      w = (i == 0) ? 4 : 8;
      if (!rst_n) begin
        rem[i] <= 0; ey[i] <= '0; ec[i] <= 1'b0; eb[i] <= 1'b0; ed[i] <= 1'b0;
      end else if (rem[i] > 0) begin
        rem[i] <= rem[i] - 1;
        if (rem[i] == 1) begin
          ey[i] <= py[i]; ec[i] <= pc[i]; ed[i] <= 1'b1; eb[i] <= 1'b0;
        end
      end else begin
        ed[i] <= 1'b0;
        if (st[i]) begin
          r = ref_op(w, imd[i], ia[i], int'(iamt[i]));
          if (iamt[i] == 0) begin
            ey[i] <= ia[i] & 8'((1 << w) - 1); ec[i] <= 1'b0; ed[i] <= 1'b1;
          end else begin
            rem[i] <= int'(iamt[i]); eb[i] <= 1'b1;
            py[i] <= r[7:0]; pc[i] <= r[8];
          end
        end
      end
    end
  end

  task automatic check(string nm, logic [7:0] act, logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      check($sformatf("cyc_y%0d", i), dy[i], ey[i]);
      check($sformatf("cyc_carry%0d", i), {7'd0, dc[i]}, {7'd0, ec[i]});
      check($sformatf("cyc_busy%0d", i), {7'd0, db[i]}, {7'd0, eb[i]});
      check($sformatf("cyc_done%0d", i), {7'd0, dd[i]}, {7'd0, ed[i]});
      if (db[i] && dd[i]) check($sformatf("busy_and_done%0d", i), 8'd1, 8'd0);
    end
  end

  // Issue one operation; if now=1 start is driven in the current cycle.
  task automatic run_op(int i, bit now, logic [7:0] a, logic [3:0] n, logic [1:0] md,
                        logic [7:0] exy, logic exc);
    int cyc;
    if (!now) @(negedge clk);
    st[i] = 1'b1; ia[i] = a; iamt[i] = n; imd[i] = md;
    @(negedge clk);
    st[i] = 1'b0;
    cyc = 0;
    while (!dd[i] && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check($sformatf("latency%0d_a%h_n%0d", i, a, n), 8'(cyc), 8'(n));
    check($sformatf("y%0d_a%h_n%0d_m%0d", i, a, n, md), dy[i], exy);
    check($sformatf("carry%0d_a%h_n%0d_m%0d", i, a, n, md), {7'd0, dc[i]}, {7'd0, exc});
  endtask

  initial begin
    int dcount;
    for (int i = 0; i < 2; i++) begin
      st[i] = 1'b0; ia[i] = '0; iamt[i] = '0; imd[i] = '0;
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_y", dy[0], 8'h00);
    check("reset_ctl", {5'd0, dc[0], db[0], dd[0]}, 8'h00);
    rst_n = 1'b1;

    check("model_asr", 8'(ref_op(8, 2'b10, 8'h96, 3)), 8'hF2);
    check("model_rol", {7'd0, ref_op(8, 2'b11, 8'h81, 9) >> 8}, 8'h01);
    check("model_lsl4", 8'(ref_op(4, 2'b00, 8'h0F, 4)), 8'h00);

    run_op(0, 0, 8'h1, 1, 2'b00, 8'h2, 1'b0);
    run_op(0, 0, 8'h3, 1, 2'b00, 8'h6, 1'b0);
    run_op(0, 0, 8'hA, 1, 2'b00, 8'h4, 1'b1);
    run_op(0, 0, 8'hF, 1, 2'b00, 8'hE, 1'b1);
    run_op(1, 0, 8'h96, 3, 2'b10, 8'hF2, 1'b1);
    run_op(1, 0, 8'h96, 3, 2'b01, 8'h12, 1'b1);
    run_op(1, 0, 8'h81, 9, 2'b11, 8'h03, 1'b1);
    run_op(0, 0, 8'hB, 0, 2'b11, 8'hB, 1'b0);
    run_op(0, 1, 8'h3, 2, 2'b00, 8'hC, 1'b0);
    run_op(0, 0, 8'hF, 7, 2'b00, 8'h0, 1'b0);
    run_op(0, 0, 8'h8, 7, 2'b10, 8'hF, 1'b1);
    run_op(0, 0, 8'hF, 4, 2'b00, 8'h0, 1'b1);

    // start held high through the SHIFT phase must not re-trigger
    @(negedge clk);
    st[0] = 1'b1; ia[0] = 8'h1; iamt[0] = 3; imd[0] = 2'b00;
    dcount = 0;
    repeat (4) begin
      @(negedge clk);
      ia[0] = 8'h5; imd[0] = 2'b01; iamt[0] = 1;
      if (dd[0]) dcount++;
    end
    st[0] = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (dd[0]) dcount++;
    end
    check("pulse_y", dy[0], 8'h8);
    check("pulse_carry", {7'd0, dc[0]}, 8'h00);
    check("pulse_done_count", 8'(dcount), 8'd1);

    // asynchronous reset in the middle of a shift
    run_op(0, 0, 8'h6, 1, 2'b00, 8'hC, 1'b0);
    @(negedge clk);
    st[0] = 1'b1; ia[0] = 8'h3; iamt[0] = 5; imd[0] = 2'b00;
    @(negedge clk);
    st[0] = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("areset_y", dy[0], 8'h00);
    check("areset_ctl", {5'd0, dc[0], db[0], dd[0]}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    dcount = 0;
    repeat (8) begin
      @(negedge clk);
      if (dd[0]) dcount++;
    end
    check("no_done_after_reset", 8'(dcount), 8'd0);
    run_op(0, 0, 8'h9, 2, 2'b11, 8'h6, 1'b0);

    // randomized traffic on both instances
    repeat (600) begin
      @(negedge clk);
      st[0] = ($urandom_range(0, 2) == 0);
      ia[0] = 8'($urandom_range(0, 15));
      iamt[0] = 4'($urandom_range(0, 7));
      imd[0] = 2'($urandom_range(0, 3));
      st[1] = ($urandom_range(0, 2) == 0);
      ia[1] = 8'($urandom_range(0, 255));
      iamt[1] = 4'($urandom_range(0, 15));
      imd[1] = 2'($urandom_range(0, 3));
    end
    st[0] = 1'b0; st[1] = 1'b0;
    repeat (20) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
